// File: rtl/det_event_sched_pkg.sv
// det_pkg: shared types and constants for the detector event scheduler.
//   src_id_t    : event source id (5/5, 5/9, packet begin, packet end)
//   out_state_t : occupancy of the single-entry event output register
//   NSRC        : number of event sources
package det_pkg;

    localparam int NSRC = 4;

    typedef enum logic [1:0] {
        SRC_55  = 2'd0,
        SRC_59  = 2'd1,
        SRC_BEG = 2'd2,
        SRC_END = 2'd3
    } src_id_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/det_event_sched_if.sv
// Event output channel of det_event_sched (valid/ready handshake).
//   evt_valid : event present (driven by scheduler)
//   evt_ready : consumer accepts the event (driven by consumer)
//   evt_id    : source id of the event, 0..3
//   evt_time  : timestamp captured when the event was loaded
// Modports: master = scheduler side, slave = consumer side.
interface det_event_sched_if #(
    parameter int TW = 16
);
    logic          evt_valid;
    logic          evt_ready;
    logic [1:0]    evt_id;
    logic [TW-1:0] evt_time;

    modport master (
        output evt_valid,
        output evt_id,
        output evt_time,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_id,
        input  evt_time,
        output evt_ready
    );
endinterface

// File: rtl/det_event_sched_rr_arbiter4.sv
// rr_arbiter4: combinational 4-way round-robin arbiter.
//   req       in  4  per-source request (pending count non-zero)
//   last      in  2  id of the most recently granted source
//   grant     out 4  one-hot grant (all zero when no request)
//   gnt_id    out 2  id of the granted source
//   gnt_valid out 1  at least one request present
// The search starts at last+1 and wraps, so the source granted last has
// the lowest priority next time. The last pointer itself lives in the parent.
module rr_arbiter4
    import det_pkg::*;
(
    input  logic [NSRC-1:0] req,
    input  src_id_t         last,
    output logic [NSRC-1:0] grant,
    output src_id_t         gnt_id,
    output logic            gnt_valid
);

    logic       found;
    logic [1:0] idx;

    always_comb begin
        grant     = '0;
        gnt_id    = SRC_55;
        found     = 1'b0;
        idx       = '0;
        // k = 1..4 visits last+1 .. last+4 (== last) modulo 4
        for (int unsigned k = 1; k <= NSRC; k++) begin
            idx = last + 2'(k);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gnt_id     = src_id_t'(idx);
            end
        end
        gnt_valid = found;
    end

endmodule

// File: rtl/det_event_sched.sv
// det_event_sched: turns rising edges of the detector level outputs into
// timestamped events, queued per source in saturating counters and
// delivered one at a time over a valid/ready channel.
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   detect55  in   5/5 detector level    (source 0)
//   detect59  in   5/9 detector level    (source 1)
//   begP      in   packet-begin level    (source 2)
//   endP      in   packet-end level      (source 3)
//   clear     in   synchronous clear of pending counters and overflow flags
//   evt       if   event channel (valid, ready, id, time), master side
//   overflow  out  sticky per-source lost-event flags
module det_event_sched
    import det_pkg::*;
#(
    parameter int TW = 16,
    parameter int PW = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                detect55,
    input  logic                detect59,
    input  logic                begP,
    input  logic                endP,
    input  logic                clear,
    det_event_sched_if.master   evt,
    output logic [NSRC-1:0]     overflow
);

    localparam logic [PW-1:0] PEND_MAX = '1;

    logic [NSRC-1:0] in_vec;
    logic [NSRC-1:0] edge_v;
    logic [NSRC-1:0] req;
    logic [NSRC-1:0] grant;
    logic [NSRC-1:0] dec_v;
    src_id_t         gnt_id;
    logic            gnt_valid;
    logic            load;

    logic [NSRC-1:0] prev_q, prev_d;
    logic [PW-1:0]   pend_q [NSRC];
    logic [PW-1:0]   pend_d [NSRC];
    logic [NSRC-1:0] ovf_q, ovf_d;
    logic [TW-1:0]   ts_q, ts_d;
    src_id_t         last_q, last_d;
    out_state_t      state_q, state_d;
    src_id_t         id_q, id_d;
    logic [TW-1:0]   time_q, time_d;

    // Edge detection and request vector (registered pend only, so an edge
    // becomes grantable one cycle after it is counted).
    always_comb begin
        in_vec = {endP, begP, detect59, detect55};
        edge_v = in_vec & ~prev_q;
        prev_d = in_vec;
        ts_d   = ts_q + TW'(1);
        for (int unsigned i = 0; i < NSRC; i++) begin
            req[i] = (pend_q[i] != '0);
        end
    end

    rr_arbiter4 u_arb (
        .req       (req),
        .last      (last_q),
        .grant     (grant),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    // Output register FSM: EMPTY loads any winner; FULL reloads or drains
    // only when the consumer takes the current event.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        time_d  = time_q;
        last_d  = last_q;
        load    = 1'b0;
        case (state_q)
            EMPTY: begin
                if (gnt_valid) begin
                    load = 1'b1;
                end
            end
            FULL: begin
                if (evt.evt_ready) begin
                    if (gnt_valid) begin
                        load = 1'b1;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
        if (load) begin
            state_d = FULL;
            id_d    = gnt_id;
            time_d  = ts_q;
            last_d  = gnt_id;
        end
    end

    // Pending counters. An edge coinciding with a grant leaves the count
    // unchanged, so it never overflows even at the ceiling. Clear overrides
    // everything, including a simultaneous edge.
    always_comb begin
        dec_v = grant & {NSRC{load}};
        ovf_d = ovf_q;
        for (int unsigned i = 0; i < NSRC; i++) begin
            pend_d[i] = pend_q[i];
            if (edge_v[i] && !dec_v[i]) begin
                if (pend_q[i] == PEND_MAX) begin
                    ovf_d[i] = 1'b1;
                end else begin
                    pend_d[i] = pend_q[i] + PW'(1);
                end
            end else if (dec_v[i] && !edge_v[i]) begin
                pend_d[i] = pend_q[i] - PW'(1);
            end
            if (clear) begin
                pend_d[i] = '0;
            end
        end
        if (clear) begin
            ovf_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q  <= '0;
            ovf_q   <= '0;
            ts_q    <= '0;
            last_q  <= SRC_END;
            state_q <= EMPTY;
            id_q    <= SRC_55;
            time_q  <= '0;
            for (int unsigned i = 0; i < NSRC; i++) begin
                pend_q[i] <= '0;
            end
        end else begin
            prev_q  <= prev_d;
            ovf_q   <= ovf_d;
            ts_q    <= ts_d;
            last_q  <= last_d;
            state_q <= state_d;
            id_q    <= id_d;
            time_q  <= time_d;
            for (int unsigned i = 0; i < NSRC; i++) begin
                pend_q[i] <= pend_d[i];
            end
        end
    end

    assign evt.evt_valid = (state_q == FULL);
    assign evt.evt_id    = id_q;
    assign evt.evt_time  = time_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_det_event_sched.sv
`timescale 1ns/1ps
module tb_det_event_sched;

    localparam int TW   = 16;
    localparam int PW   = 2;
    localparam int PMAX = (1 << PW) - 1;

    logic       clk;
    logic       reset;
    logic       detect55, detect59, begP, endP, clear;
    logic [3:0] overflow;

    det_event_sched_if #(.TW(TW)) evt_if ();

    det_event_sched #(.TW(TW), .PW(PW)) dut (
        .clk      (clk),
        .reset    (reset),
        .detect55 (detect55),
        .detect59 (detect59),
        .begP     (begP),
        .endP     (endP),
        .clear    (clear),
        .evt      (evt_if),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: per-source pending queues as plain integer counts.
    int       m_pend [4];
    bit [3:0] m_ovf;
    bit [3:0] m_prev;
    int       m_ts;
    int       m_last;
    bit       m_valid;
    int       m_id;
    int       m_time;

    task automatic model_reset();
        m_pend  = '{default: 0};
        m_ovf   = '0;
        m_prev  = '0;
        m_ts    = 0;
        m_last  = 3;
        m_valid = 0;
        m_id    = 0;
        m_time  = 0;
    endtask

    // Advance the model by one clock using the inputs as they stand, then
    // let the DUT take the same edge and settle.
    task automatic step();
        bit [3:0] in_v;
        int       winner;
        bit       take;
        in_v   = {endP, begP, detect59, detect55};
        winner = -1;
        for (int k = 1; k <= 4; k++) begin
            int s;
            s = (m_last + k) % 4;
            if (winner < 0 && m_pend[s] > 0) winner = s;
        end
        take = (winner >= 0) && (!m_valid || evt_if.evt_ready);
        for (int i = 0; i < 4; i++) begin
            int n;
            n = m_pend[i] + ((in_v[i] && !m_prev[i]) ? 1 : 0)
                          - ((take && winner == i) ? 1 : 0);
            if (n > PMAX) begin
                n = PMAX;
                m_ovf[i] = 1'b1;
            end
            m_pend[i] = n;
        end
        if (clear) begin
            m_pend = '{default: 0};
            m_ovf  = '0;
        end
        if (take) begin
            m_valid = 1;
            m_id    = winner;
            m_time  = m_ts;
            m_last  = winner;
        end else if (m_valid && evt_if.evt_ready) begin
            m_valid = 0;
        end
        m_ts   = (m_ts + 1) % (1 << TW);
        m_prev = in_v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        checks++;
        if (evt_if.evt_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %0b expected 0", evt_if.evt_valid);
        end
        checks++;
        if (evt_if.evt_id !== 2'd0) begin
            errors++; $display("FAIL reset_id: got %0d expected 0", evt_if.evt_id);
        end
        checks++;
        if (evt_if.evt_time !== 16'd0) begin
            errors++; $display("FAIL reset_time: got %0d expected 0", evt_if.evt_time);
        end
        checks++;
        if (overflow !== 4'd0) begin
            errors++; $display("FAIL reset_overflow: got %b expected 0000", overflow);
        end
        model_reset();
        reset = 1'b1;
    endtask

    task automatic test_single();
        evt_if.evt_ready = 1'b1;
        detect55 = 1'b1;
        step();
        detect55 = 1'b0;
        checks++;
        if (evt_if.evt_valid !== 1'b0) begin
            errors++; $display("FAIL single_early: got valid=%0b expected 0", evt_if.evt_valid);
        end
        step();
        checks++;
        if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== 2'd0) begin
            errors++; $display("FAIL single_event: got valid=%0b id=%0d expected valid=1 id=0",
                               evt_if.evt_valid, evt_if.evt_id);
        end
        checks++;
        if (evt_if.evt_time !== 16'(m_time)) begin
            errors++; $display("FAIL single_time: got %0d expected %0d", evt_if.evt_time, m_time);
        end
        step();
        checks++;
        if (evt_if.evt_valid !== 1'b0) begin
            errors++; $display("FAIL single_drain: got valid=%0b expected 0", evt_if.evt_valid);
        end
    endtask

    task automatic test_all4();
        evt_if.evt_ready = 1'b1;
        do_reset();
        for (int r = 0; r < 2; r++) begin
            {endP, begP, detect59, detect55} = 4'b1111;
            step();
            {endP, begP, detect59, detect55} = 4'b0000;
            for (int k = 0; k < 4; k++) begin
                step();
                checks++;
                if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== 2'(k)) begin
                    errors++; $display("FAIL all4_order round %0d slot %0d: got valid=%0b id=%0d expected valid=1 id=%0d",
                                       r, k, evt_if.evt_valid, evt_if.evt_id, k);
                end
            end
            step();
            checks++;
            if (evt_if.evt_valid !== 1'b0) begin
                errors++; $display("FAIL all4_drain round %0d: got valid=%0b expected 0", r, evt_if.evt_valid);
            end
        end
    endtask

    // Output is first filled with a detect55 event held by ready=0, so the
    // four begP pulses all land in pend[2]; the fourth overflows.
    task automatic test_overflow();
        int n2;
        int nv;
        do_reset();
        evt_if.evt_ready = 1'b0;
        detect55 = 1'b1; step();
        detect55 = 1'b0; step();
        for (int p = 0; p < 4; p++) begin
            begP = 1'b1; step();
            begP = 1'b0; step();
        end
        checks++;
        if (overflow !== 4'b0100) begin
            errors++; $display("FAIL ovf_flag: got %b expected 0100", overflow);
        end
        checks++;
        if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== 2'd0) begin
            errors++; $display("FAIL ovf_head: got valid=%0b id=%0d expected valid=1 id=0",
                               evt_if.evt_valid, evt_if.evt_id);
        end
        evt_if.evt_ready = 1'b1;
        n2 = 0;
        nv = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (evt_if.evt_valid === 1'b1) begin
                nv++;
                if (evt_if.evt_id === 2'd2) n2++;
            end
        end
        checks++;
        if (n2 != 3 || nv != 3) begin
            errors++; $display("FAIL ovf_drain: got id2=%0d total=%0d expected id2=3 total=3", n2, nv);
        end
    endtask

    task automatic test_hold();
        logic [1:0]    hid;
        logic [TW-1:0] htime;
        int            exp_t;
        evt_if.evt_ready = 1'b0;
        detect59 = 1'b1; step();
        detect59 = 1'b0; step();
        endP = 1'b1; step();
        endP = 1'b0; step();
        hid   = evt_if.evt_id;
        htime = evt_if.evt_time;
        checks++;
        if (hid !== 2'd1 || htime !== 16'(m_time)) begin
            errors++; $display("FAIL hold_load: got id=%0d time=%0d expected id=1 time=%0d", hid, htime, m_time);
        end
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== hid || evt_if.evt_time !== htime) begin
                errors++; $display("FAIL hold_stable cycle %0d: got valid=%0b id=%0d time=%0d expected valid=1 id=%0d time=%0d",
                                   c, evt_if.evt_valid, evt_if.evt_id, evt_if.evt_time, hid, htime);
            end
        end
        exp_t = m_ts;
        evt_if.evt_ready = 1'b1;
        step();
        checks++;
        if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== 2'd3 || evt_if.evt_time !== 16'(exp_t)) begin
            errors++; $display("FAIL hold_next: got valid=%0b id=%0d time=%0d expected valid=1 id=3 time=%0d",
                               evt_if.evt_valid, evt_if.evt_id, evt_if.evt_time, exp_t);
        end
        step();
    endtask

    task automatic test_clear();
        int n3;
        int nv;
        checks++;
        if (overflow !== 4'b0100) begin
            errors++; $display("FAIL clear_pre: got overflow=%b expected 0100", overflow);
        end
        evt_if.evt_ready = 1'b0;
        detect55 = 1'b1; step();
        detect55 = 1'b0; step();
        endP  = 1'b1;
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++;
        if (overflow !== 4'b0000) begin
            errors++; $display("FAIL clear_ovf: got %b expected 0000", overflow);
        end
        checks++;
        if (evt_if.evt_valid !== 1'b1 || evt_if.evt_id !== 2'd0) begin
            errors++; $display("FAIL clear_keep: got valid=%0b id=%0d expected valid=1 id=0",
                               evt_if.evt_valid, evt_if.evt_id);
        end
        evt_if.evt_ready = 1'b1;
        n3 = 0;
        nv = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (evt_if.evt_valid === 1'b1) begin
                nv++;
                if (evt_if.evt_id === 2'd3) n3++;
            end
        end
        checks++;
        if (n3 != 0 || nv != 0) begin
            errors++; $display("FAIL clear_drop: got id3=%0d extra=%0d expected 0 and 0", n3, nv);
        end
        endP = 1'b0;
        step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            detect55 = ($urandom_range(0, 2) == 0);
            detect59 = ($urandom_range(0, 2) == 0);
            begP     = ($urandom_range(0, 3) == 0);
            endP     = ($urandom_range(0, 3) == 0);
            clear    = ($urandom_range(0, 31) == 0);
            evt_if.evt_ready = ($urandom_range(0, 3) != 0);
            step();
            checks++;
            if (evt_if.evt_valid !== m_valid || evt_if.evt_id !== 2'(m_id) ||
                evt_if.evt_time !== 16'(m_time) || overflow !== m_ovf) begin
                errors++; $display("FAIL random cycle %0d: got v=%0b id=%0d t=%0d ovf=%b expected v=%0b id=%0d t=%0d ovf=%b",
                                   c, evt_if.evt_valid, evt_if.evt_id, evt_if.evt_time, overflow,
                                   m_valid, m_id, m_time, m_ovf);
            end
        end
        {endP, begP, detect59, detect55} = 4'b0000;
        clear = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n1;
        int nv;
        evt_if.evt_ready = 1'b1;
        for (int c = 0; c < 8; c++) step();
        evt_if.evt_ready = 1'b0;
        detect55 = 1'b1; step();
        detect55 = 1'b0; step();
        checks++;
        if (evt_if.evt_valid !== 1'b1) begin
            errors++; $display("FAIL mid_pre: got valid=%0b expected 1", evt_if.evt_valid);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (evt_if.evt_valid !== 1'b0 || evt_if.evt_id !== 2'd0 ||
            evt_if.evt_time !== 16'd0 || overflow !== 4'd0) begin
            errors++; $display("FAIL mid_async: got v=%0b id=%0d t=%0d ovf=%b expected all 0",
                               evt_if.evt_valid, evt_if.evt_id, evt_if.evt_time, overflow);
        end
        model_reset();
        detect59 = 1'b1;
        evt_if.evt_ready = 1'b1;
        #1;
        reset = 1'b1;
        n1 = 0;
        nv = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (evt_if.evt_valid === 1'b1) begin
                nv++;
                if (evt_if.evt_id === 2'd1) n1++;
            end
        end
        checks++;
        if (n1 != 1 || nv != 1) begin
            errors++; $display("FAIL mid_after: got id1=%0d total=%0d expected 1 and 1", n1, nv);
        end
        detect59 = 1'b0;
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b0;
        {endP, begP, detect59, detect55} = 4'b0000;
        clear = 1'b0;
        evt_if.evt_ready = 1'b0;
        model_reset();
        #2;
        test_reset();
        test_single();
        test_all4();
        test_overflow();
        test_hold();
        test_clear();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
